// File: rtl/spi_slave_if.sv
// SPI slave serial front end: 10-bit {cmd, payload} frame capture and MISO readback of the RAM byte.
// Optional SPI_FRAME_ERR_EN adds a frame_err pulse on frames or readbacks cut short by SS_n.
module spi_slave_if #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TX_CW   = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [FRAME_W-2:0]  rx_shift;
  logic                rd_addr_seen;
  logic [DATA_W-1:0]   tx_shift;
  logic [TX_CW-1:0]    tx_left;
  logic                tx_loaded;

  logic frame_done, last_bit;
  assign frame_done = (bit_cnt == CNT_W'(FRAME_W));
  assign last_bit   = (bit_cnt == CNT_W'(FRAME_W - 1));

`ifdef SPI_FRAME_ERR_EN
  // A frame is partial from the command bit until the last bit lands; readback until its last bit is driven.
  logic cut_short;
  assign cut_short = (state == CHK_CMD) ||
                     ((state != IDLE) && (bit_cnt != '0) && !frame_done) ||
                     (tx_left != '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
      MISO         <= 1'b0;
      tx_shift     <= '0;
      tx_left      <= '0;
      tx_loaded    <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err    <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      if (SS_n) begin
        // Deselect wins over everything, including the last frame bit.
        state     <= IDLE;
        bit_cnt   <= '0;
        MISO      <= 1'b0;
        tx_shift  <= '0;
        tx_left   <= '0;
        tx_loaded <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
        frame_err <= cut_short;
`endif
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;
          CHK_CMD: begin
            rx_shift <= {rx_shift[FRAME_W-3:0], MOSI};
            bit_cnt  <= CNT_W'(1);
            if (!MOSI)            state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                  state <= READ_ADD;
          end
          default: begin
            if (!frame_done) begin
              bit_cnt  <= bit_cnt + CNT_W'(1);
              rx_shift <= {rx_shift[FRAME_W-3:0], MOSI};
              if (last_bit) begin
                rx_data  <= {rx_shift, MOSI};
                rx_valid <= 1'b1;
                if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                if (state == READ_DATA) rd_addr_seen <= 1'b0;
              end
            end else if (state == READ_DATA) begin
              if (tx_left != '0) begin
                MISO     <= tx_shift[DATA_W-1];
                tx_shift <= tx_shift << 1;
                tx_left  <= tx_left - TX_CW'(1);
              end else begin
                MISO <= 1'b0;
                // Only one load per READ_DATA frame, however long tx_valid is held.
                if (tx_valid && !tx_loaded) begin
                  MISO      <= tx_data[DATA_W-1];
                  tx_shift  <= tx_data << 1;
                  tx_left   <= TX_CW'(DATA_W - 1);
                  tx_loaded <= 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: frame capture, read/readback sequencing, aborts, reset.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  spi_slave_if #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ss_high();
    SS_n = 1'b1;
    tick();
  endtask

  // Full frame from IDLE; rx_valid must appear exactly after the 11th edge.
  task automatic send_frame(input string tag, input logic [9:0] w);
    int early;
    early = 0;
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick();
    if (rx_valid) early++;
    for (int i = 9; i >= 0; i--) begin
      MOSI = w[i];
      tick();
      if (i > 0 && rx_valid) early++;
    end
    chk({tag, " early_vld"}, early, 0);
    chk({tag, " vld"}, rx_valid, 1);
    chk({tag, " data"}, rx_data, w);
    MOSI = ~MOSI;
    tick();
    chk({tag, " vld_1cyc"}, rx_valid, 0);
    chk({tag, " data_hold"}, rx_data, w);
  endtask

  initial begin
    int hits;
    logic [8:0] bits;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
    #12;
    chk("rst MISO", MISO, 0);
    chk("rst rx_data", rx_data, 0);
    chk("rst rx_valid", rx_valid, 0);
    chk("rst seen", dut.rd_addr_seen, 0);
    rst_n = 1'b1;
    tick(); tick();

    send_frame("wr_addr", 10'h02A);
    ss_high();

    // tx_valid outside READ_DATA must not drive MISO
    send_frame("wr_data", 10'h15C);
    tx_data = 8'hFF; tx_valid = 1'b1; hits = 0;
    repeat (3) begin tick(); hits += int'(MISO); end
    tx_valid = 1'b0;
    chk("wr_data miso_quiet", hits, 0);
    chk("wr_data seen", dut.rd_addr_seen, 0);
    ss_high();

    send_frame("rd_addr", 10'h22A);
    chk("rd_addr seen", dut.rd_addr_seen, 1);
    tx_valid = 1'b1; hits = 0;
    repeat (3) begin tick(); hits += int'(MISO); end
    tx_valid = 1'b0;
    chk("rd_addr miso_quiet", hits, 0);
    ss_high();

    send_frame("rd_data", 10'h300);
    chk("rd_data seen", dut.rd_addr_seen, 0);
    tx_data = 8'h5C; bits = '0;
    for (int k = 0; k < 9; k++) begin
      tx_valid = (k < 3) || (k == 5);
      tick();
      bits = {bits[7:0], MISO};
    end
    chk("readback seq", bits, 9'b010111000);
    tx_valid = 1'b1; hits = 0;
    repeat (3) begin tick(); hits += int'(MISO); end
    tx_valid = 1'b0;
    chk("readback one_load", hits, 0);
    ss_high();
`ifdef SPI_FRAME_ERR_EN
    chk("readback done no_err", frame_err, 0);
`endif

    // seen was cleared: an 11 frame is now READ_ADD and must not read back
    send_frame("rd_again", 10'h3A5);
    tx_data = 8'hFF; tx_valid = 1'b1; hits = 0;
    repeat (3) begin tick(); hits += int'(MISO); end
    tx_valid = 1'b0;
    chk("rd_again miso_quiet", hits, 0);
    chk("rd_again seen", dut.rd_addr_seen, 1);
    ss_high();
    send_frame("rd_clr", 10'h300);
    chk("rd_clr seen", dut.rd_addr_seen, 0);
    ss_high();

    // Abort after 5 bits
    SS_n = 1'b0; tick();
    hits = 0;
    for (int i = 0; i < 5; i++) begin MOSI = i[0]; tick(); hits += int'(rx_valid); end
    SS_n = 1'b1; tick(); hits += int'(rx_valid);
    chk("abort5 no_vld", hits, 0);
    chk("abort5 data", rx_data, 10'h300);
`ifdef SPI_FRAME_ERR_EN
    chk("abort5 err", frame_err, 1);
    tick();
    chk("abort5 err_1cyc", frame_err, 0);
`endif

    // Abort on the edge of the last bit of a read-addr frame
    SS_n = 1'b0; tick();
    for (int i = 9; i >= 1; i--) begin MOSI = (i == 9) || i[0]; tick(); end
    MOSI = 1'b1; SS_n = 1'b1; tick();
    chk("abort_last no_vld", rx_valid, 0);
    chk("abort_last data", rx_data, 10'h300);
    chk("abort_last seen", dut.rd_addr_seen, 0);
`ifdef SPI_FRAME_ERR_EN
    chk("abort_last err", frame_err, 1);
`endif

    send_frame("b2b0", 10'h0A5);
    ss_high();
    send_frame("b2b1", 10'h15A);
    ss_high();

    // Async reset mid-readback
    send_frame("rst_ra", 10'h200);
    ss_high();
    send_frame("rst_rd", 10'h3C3);
    tx_data = 8'hFF; tx_valid = 1'b1;
    repeat (3) tick();
    chk("pre_rst MISO", MISO, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async MISO", MISO, 0);
    chk("async rx_data", rx_data, 0);
    chk("async rx_valid", rx_valid, 0);
    chk("async seen", dut.rd_addr_seen, 0);
    tx_valid = 1'b0; SS_n = 1'b1;
    #3 rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
